// File: rtl/lab3_mem_line_to_word_adapter_if.sv
// Handshake bundle between the cache line port, the adapter and word memory.
// The adapter takes the slave view; cache and memory together take master.
interface lab3_mem_line_to_word_adapter_if #(
    parameter int p_nwords    = 4,
    parameter int p_opq_nbits = 8
);
    localparam int LW = 32 * p_nwords;

    logic                   linereq_val;
    logic                   linereq_rdy;
    logic [2:0]             linereq_type;
    logic [p_opq_nbits-1:0] linereq_opaque;
    logic [31:0]            linereq_addr;
    logic [LW-1:0]          linereq_data;

    logic                   lineresp_val;
    logic                   lineresp_rdy;
    logic [2:0]             lineresp_type;
    logic [p_opq_nbits-1:0] lineresp_opaque;
    logic [LW-1:0]          lineresp_data;

    logic                   wordreq_val;
    logic                   wordreq_rdy;
    logic [2:0]             wordreq_type;
    logic [p_opq_nbits-1:0] wordreq_opaque;
    logic [31:0]            wordreq_addr;
    logic [31:0]            wordreq_data;

    logic                   wordresp_val;
    logic                   wordresp_rdy;
    logic [2:0]             wordresp_type;
    logic [p_opq_nbits-1:0] wordresp_opaque;
    logic [31:0]            wordresp_data;

    modport slave (
        input  linereq_val, linereq_type, linereq_opaque,
        input  linereq_addr, linereq_data,
        output linereq_rdy,
        output lineresp_val, lineresp_type, lineresp_opaque,
        output lineresp_data,
        input  lineresp_rdy,
        output wordreq_val, wordreq_type, wordreq_opaque,
        output wordreq_addr, wordreq_data,
        input  wordreq_rdy,
        input  wordresp_val, wordresp_type, wordresp_opaque,
        input  wordresp_data,
        output wordresp_rdy
    );

    modport master (
        output linereq_val, linereq_type, linereq_opaque,
        output linereq_addr, linereq_data,
        input  linereq_rdy,
        input  lineresp_val, lineresp_type, lineresp_opaque,
        input  lineresp_data,
        output lineresp_rdy,
        input  wordreq_val, wordreq_type, wordreq_opaque,
        input  wordreq_addr, wordreq_data,
        output wordreq_rdy,
        output wordresp_val, wordresp_type, wordresp_opaque,
        output wordresp_data,
        input  wordresp_rdy
    );
endinterface

// File: rtl/lab3_mem_line_to_word_adapter.sv
// Splits cache line requests into pipelined word requests and reassembles.
// Define LAB3_MEM_LINE_ADAPTER_CWF_EN to issue the critical word first.
module lab3_mem_line_to_word_adapter #(
    parameter int p_nwords    = 4,
    parameter int p_opq_nbits = 8
) (
    input logic clk,
    input logic reset,
    lab3_mem_line_to_word_adapter_if.slave bus
);
    localparam int IW = $clog2(p_nwords);
    localparam int LW = 32 * p_nwords;
    localparam int BW = 32 - IW - 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IW:0]            issue_cnt;
    logic [p_nwords-1:0]    recv_mask;
    logic [p_nwords-1:0]    mask_upd;
    logic [LW-1:0]          line_buf;
    logic [2:0]             lat_type;
    logic [p_opq_nbits-1:0] lat_opq;
    logic [BW-1:0]          lat_base;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          resp_idx;
    logic                   lat_rd;
    logic                   linereq_go;
    logic                   lineresp_go;
    logic                   wordreq_go;
    logic                   wordresp_go;
    logic                   last_issue;
    logic                   all_recv;
    logic                   unused_bits;

    assign linereq_go  = bus.linereq_val & bus.linereq_rdy;
    assign lineresp_go = bus.lineresp_val & bus.lineresp_rdy;
    assign wordreq_go  = bus.wordreq_val & bus.wordreq_rdy;
    assign wordresp_go = bus.wordresp_val & bus.wordresp_rdy;

    assign lat_rd     = (lat_type == 3'd0);
    assign resp_idx   = bus.wordresp_opaque[IW-1:0];
    assign last_issue = (issue_cnt == (IW+1)'(p_nwords - 1));

    // Completion looks at the mask including this cycle's response
    assign mask_upd = recv_mask
                    | ({p_nwords{wordresp_go}}
                       & ({{(p_nwords-1){1'b0}}, 1'b1} << resp_idx));
    assign all_recv = &mask_upd;

`ifdef LAB3_MEM_LINE_ADAPTER_CWF_EN
    logic [IW-1:0] start_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_idx <= '0;
        end else if (linereq_go) begin
            start_idx <= bus.linereq_addr[IW+1:2];
        end
    end

    assign idx = issue_cnt[IW-1:0] + start_idx;
    assign unused_bits = ^{bus.linereq_addr[1:0],
                           bus.wordresp_opaque[p_opq_nbits-1:IW],
                           bus.wordresp_type};
`else
    assign idx = issue_cnt[IW-1:0];
    assign unused_bits = ^{bus.linereq_addr[IW+1:0],
                           bus.wordresp_opaque[p_opq_nbits-1:IW],
                           bus.wordresp_type};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (linereq_go) state_nxt = ISSUE;
            ISSUE:   if (wordreq_go && last_issue)
                         state_nxt = all_recv ? RESP : DRAIN;
            DRAIN:   if (all_recv) state_nxt = RESP;
            RESP:    if (lineresp_go) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.linereq_rdy  = 1'b0;
        bus.wordreq_val  = 1'b0;
        bus.wordresp_rdy = 1'b0;
        bus.lineresp_val = 1'b0;
        unique case (1'b1)
            (state == IDLE):  bus.linereq_rdy = reset;
            (state == ISSUE): begin
                bus.wordreq_val  = 1'b1;
                bus.wordresp_rdy = 1'b1;
            end
            (state == DRAIN): bus.wordresp_rdy = 1'b1;
            (state == RESP):  bus.lineresp_val = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_cnt <= '0;
            recv_mask <= '0;
            line_buf  <= '0;
            lat_type  <= '0;
            lat_opq   <= '0;
            lat_base  <= '0;
        end else begin
            if (linereq_go) begin
                lat_type  <= bus.linereq_type;
                lat_opq   <= bus.linereq_opaque;
                lat_base  <= bus.linereq_addr[31:IW+2];
                line_buf  <= (bus.linereq_type == 3'd0)
                           ? '0 : bus.linereq_data;
                recv_mask <= '0;
                issue_cnt <= '0;
            end
            if (wordreq_go && issue_cnt != (IW+1)'(p_nwords)) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (wordresp_go) begin
                recv_mask <= mask_upd;
                if (lat_rd) begin
                    line_buf[32*resp_idx +: 32] <= bus.wordresp_data;
                end
            end
            if (lineresp_go) begin
                issue_cnt <= '0;
                recv_mask <= '0;
            end
        end
    end

    assign bus.lineresp_type   = lat_type;
    assign bus.lineresp_opaque = lat_opq;
    assign bus.lineresp_data   = lat_rd ? line_buf : '0;

    assign bus.wordreq_type   = lat_rd ? 3'd0 : 3'd1;
    assign bus.wordreq_opaque = {{(p_opq_nbits-IW){1'b0}}, idx};
    assign bus.wordreq_addr   = {lat_base, idx, 2'b00};
    assign bus.wordreq_data   = lat_rd ? 32'd0 : line_buf[32*idx +: 32];

    // Memory must answer each word once, with the type it was asked for
    dup_resp_a: assert property (@(posedge clk) disable iff (!reset)
        wordresp_go |-> !recv_mask[resp_idx]);

    resp_type_a: assert property (@(posedge clk) disable iff (!reset)
        wordresp_go |-> (bus.wordresp_type == bus.wordreq_type));
endmodule
